phase_error_detector: RTL and testbench

PHASE_ERROR_DETECTOR -- requirements
Module: phase_error_detector

---
 rtl/adpll_pkg.sv | 5 +
 rtl/edge_sync.sv | 34 +++
 rtl/phase_error_detector.sv | 67 ++++++
 tb/tb_phase_error_detector.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// adpll_pkg: shared ADPLL constants and phase detector state type
package adpll_pkg;
  localparam int ERROR_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} ped_state_e;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: multi-flop synchroniser followed by a rising-edge detector
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   arm_q, arm_d;
  logic [SYNC_STAGES:0]   chain;
  logic                   prev_q, prev_d;
  // shift the input through the chain; arm only once prev holds a real sample
  // so a level already high at reset release never looks like an edge
  always_comb begin
    chain  = {sync_q, d_i};
    sync_d = chain[SYNC_STAGES-1:0];
    arm_d  = {arm_q[SYNC_STAGES-1:0], 1'b1};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  // synchroniser, edge-detect and arming flops
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      sync_q <= '0;
      arm_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      arm_q  <= arm_d;
      prev_q <= prev_d;
    end
  assign rise_o = arm_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/phase_error_detector.sv
// phase_error_detector: signed cycle-count phase error between ref and fb clocks
module phase_error_detector
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH = ERROR_WIDTH_DEF,
  parameter int MAX_COUNT   = 127,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   ref_i,
  input  logic                   fb_i,
  output logic [ERROR_WIDTH-1:0] error_o,
  output logic                   error_valid_o
);
  localparam int CW = ERROR_WIDTH - 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);
  logic                   ref_rise, fb_rise;
  ped_state_e             state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [ERROR_WIDTH-1:0] error_q, error_d, mag;
  logic                   valid_q, valid_d;
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(ref_i), .rise_o(ref_rise)
  );
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(fb_i), .rise_o(fb_rise)
  );
  // measurement FSM: open on the first edge, close on the other edge or at saturation
  always_comb begin
    mag     = {1'b0, count_q};
    state_d = state_q;
    count_d = count_q + 1'b1;
    error_d = error_q;
    valid_d = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (state_q == IDLE) begin
      state_d = (ref_rise && !fb_rise) ? REF_LEAD : (fb_rise && !ref_rise) ? FB_LEAD : IDLE;
      count_d = (ref_rise ^ fb_rise) ? CW'(1) : '0;
      valid_d = ref_rise && fb_rise;
      error_d = (ref_rise && fb_rise) ? '0 : error_q;
    end else if ((state_q == REF_LEAD && fb_rise) || (state_q == FB_LEAD && ref_rise) || count_q == MAX_C) begin
      state_d = IDLE;
      count_d = '0;
      valid_d = 1'b1;
      error_d = (state_q == REF_LEAD) ? mag : -mag;
    end
  end
  // state, counter and registered outputs
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= '0;
      error_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
      valid_q <= valid_d;
    end
  assign error_o       = error_q;
  assign error_valid_o = valid_q;
endmodule

// File: tb/tb_phase_error_detector.sv
// tb_phase_error_detector: directed and randomized checks against a lead/lag reference model
module tb_phase_error_detector;
  localparam int MAXC = 127;
  localparam int SYNC = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       ref_s = 1'b0;
  logic       fb_s = 1'b0;
  logic [7:0] err;
  logic       valid;
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_last = 0;

  phase_error_detector #(.ERROR_WIDTH(8), .MAX_COUNT(MAXC), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .ref_i(ref_s), .fb_i(fb_s),
    .error_o(err), .error_valid_o(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(want));
    end
  endtask

  function automatic logic [31:0] err_int();
    return 32'($signed(err));
  endfunction

  // lower both inputs, let the levels settle, confirm the output held
  task automatic settle(input int n);
    ref_s = 1'b0;
    fb_s  = 1'b0;
    repeat (n) @(posedge clk);
    #1 chk("hold", err_int(), exp_last);
  endtask

  // d > 0: ref leads fb by d cycles; d < 0: fb leads; close=0 never sends the lagging edge.
  // Model: error is the lead clamped to +-MAX, valid exactly once, SYNC+1+|error| edges
  // after the first edge that samples the leading input.
  task automatic measure(input int d, input bit close);
    int ad, lat, strobes, at, want;
    logic [31:0] val;
    ad      = d < 0 ? -d : d;
    want    = !close ? (d < 0 ? -MAXC : MAXC) : (d > MAXC ? MAXC : d < -MAXC ? -MAXC : d);
    lat     = SYNC + 1 + (want < 0 ? -want : want);
    strobes = 0;
    at      = -1;
    val     = 'x;
    @(negedge clk);
    if (d >= 0) ref_s = 1'b1;
    if (d <= 0) fb_s = 1'b1;
    for (int c = 1; c <= lat + 4; c++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        strobes++;
        at  = c;
        val = err_int();
      end
      if (close && d != 0 && c == ad) begin
        if (d > 0) fb_s = 1'b1;
        else ref_s = 1'b1;
      end
    end
    chk("strobe_count", strobes, 1);
    chk("strobe_cycle", at, lat);
    chk("error_value", val, want);
    exp_last = want;
  endtask

  task automatic no_strobe(input string tag, input int n);
    int s;
    s = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1 if (valid) s++;
    end
    chk(tag, s, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_error", err_int(), 0);
    chk("reset_valid", valid, 0);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);
    measure(5, 1);
    settle(4);
    measure(-12, 1);
    settle(4);
    measure(0, 1);
    settle(4);
    measure(200, 0);
    settle(4);
    measure(-9, 1);
    settle(4);
    measure(MAXC, 1);
    settle(4);
    measure(-(MAXC - 1), 1);
    settle(4);
    measure(1, 1);
    settle(4);
    // enable dropped mid-measurement abandons it
    @(negedge clk) ref_s = 1'b1;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 fb_s = 1'b1;
    no_strobe("disabled_strobe", 20);
    chk("disabled_hold", err_int(), exp_last);
    settle(4);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    measure(4, 1);
    settle(4);
    // asynchronous reset in the middle of a ref-lead measurement
    @(negedge clk) ref_s = 1'b1;
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_error", err_int(), 0);
    chk("async_reset_valid", valid, 0);
    exp_last = 0;
    @(negedge clk) reset = 1'b0;
    no_strobe("stale_edge_strobe", 150);
    settle(4);
    measure(-3, 1);
    settle(4);
    for (int i = 0; i < 14; i++) begin
      measure(int'($urandom_range(0, 2 * MAXC)) - MAXC, 1);
      settle(3 + int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 2; i++) begin
      measure($urandom_range(0, 1) ? 50 : -50, 0);
      settle(4);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
